// File: rtl/usb_sie_turnaround_ctrl.sv
// usb_sie_turnaround_ctrl
// Half-duplex bus-turnaround scheduler between the protocol engine and the
// USB SIE (12 MHz domain, one cycle per FS bit time). It owns the SIE phase
// select and transmit-start pulse, enforces the inter-packet delay, times
// out missing host responses and aborts runaway transmissions.
// Optional build macro USB_TURNAROUND_STATS_EN adds saturating timeout and
// abort statistics counters.
module usb_sie_turnaround_ctrl #(
    parameter int MIN_IPD_CYCLES      = 2,
    parameter int TX_SETUP_CYCLES     = 1,
    parameter int RESP_TIMEOUT_CYCLES = 18,
    parameter int TX_WATCHDOG_CYCLES  = 12000
`ifdef USB_TURNAROUND_STATS_EN
    ,
    parameter int STAT_W              = 8
`endif
) (
    input  logic clk12_i,
    input  logic rst_i,
    input  logic usbResetDetected_i,
    input  logic rxDPPLGotSignal_i,
    input  logic rxPacketDone_i,
    input  logic txReqSend_i,
    input  logic txExpectResponse_i,
    input  logic txDoneSending_i,
    output logic txGrant_o,
    output logic isSendingPhase_o,
    output logic txReqSendPacket_o,
    output logic rxTimeout_o,
    output logic txAbort_o,
    output logic busy_o
`ifdef USB_TURNAROUND_STATS_EN
    ,
    output logic [STAT_W-1:0] timeoutCount_o,
    output logic [STAT_W-1:0] abortCount_o
`endif
);

    localparam int IPD_W  = $clog2(MIN_IPD_CYCLES) + 1;
    localparam int SET_W  = $clog2(TX_SETUP_CYCLES) + 1;
    localparam int RESP_W = $clog2(RESP_TIMEOUT_CYCLES) + 1;
    localparam int WD_W   = $clog2(TX_WATCHDOG_CYCLES) + 1;

    localparam logic [IPD_W-1:0]  IPD_MIN   = IPD_W'(MIN_IPD_CYCLES);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(TX_SETUP_CYCLES - 1);
    localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESP_TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TX_WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_BUSY   = 3'd1,
        TX_SETUP  = 3'd2,
        TX_ACTIVE = 3'd3,
        TX_SETTLE = 3'd4,
        RESP_WAIT = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IPD_W-1:0]  ipd_cnt_r;
    logic [SET_W-1:0]  setup_cnt_r;
    logic [RESP_W-1:0] resp_cnt_r;
    logic [WD_W-1:0]   wd_cnt_r;
    logic              expect_r;
    logic              abort_r;
    logic              is_sending_r;
    logic              busy_r;
    logic              tx_pkt_r;
    logic              grant_s;
    logic              start_s;
    logic              timeout_s;
    logic              abort_s;

    // Next-state decode and the single-cycle handshake pulses.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        start_s     = 1'b0;
        timeout_s   = 1'b0;
        abort_s     = 1'b0;
        if (usbResetDetected_i) begin
            state_nxt_s = RX_IDLE;
        end else begin
            case (state_r)
                RX_IDLE: begin
                    if (rxDPPLGotSignal_i) begin
                        state_nxt_s = RX_BUSY;
                    end else if (txReqSend_i && (ipd_cnt_r >= IPD_MIN)) begin
                        state_nxt_s = TX_SETUP;
                        grant_s     = 1'b1;
                    end else begin
                        state_nxt_s = RX_IDLE;
                    end
                end
                RX_BUSY: begin
                    if (rxPacketDone_i) begin
                        state_nxt_s = RX_IDLE;
                    end else begin
                        state_nxt_s = RX_BUSY;
                    end
                end
                TX_SETUP: begin
                    if (setup_cnt_r == SET_LAST) begin
                        state_nxt_s = TX_ACTIVE;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = TX_SETUP;
                    end
                end
                TX_ACTIVE: begin
                    // Done has priority over a coincident watchdog expiry.
                    if (txDoneSending_i) begin
                        state_nxt_s = TX_SETTLE;
                    end else if (wd_cnt_r == WD_LAST) begin
                        state_nxt_s = TX_SETTLE;
                        abort_s     = 1'b1;
                    end else begin
                        state_nxt_s = TX_ACTIVE;
                    end
                end
                TX_SETTLE: begin
                    if (expect_r && !abort_r) begin
                        state_nxt_s = RESP_WAIT;
                    end else begin
                        state_nxt_s = RX_IDLE;
                    end
                end
                RESP_WAIT: begin
                    // An arriving packet beats a coincident timeout.
                    if (rxDPPLGotSignal_i) begin
                        state_nxt_s = RX_BUSY;
                    end else if (resp_cnt_r == RESP_LAST) begin
                        state_nxt_s = RX_IDLE;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = RESP_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = RX_IDLE;
                end
            endcase
        end
    end

    // State register with registered phase-select, busy and start outputs.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= RX_IDLE;
            is_sending_r <= 1'b0;
            busy_r       <= 1'b0;
            tx_pkt_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            is_sending_r <= (state_nxt_s == TX_SETUP) || (state_nxt_s == TX_ACTIVE);
            busy_r       <= (state_nxt_s != RX_IDLE);
            tx_pkt_r     <= start_s;
        end
    end

    // Interval counters; each runs only while its owning state persists.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            ipd_cnt_r   <= '0;
            setup_cnt_r <= '0;
            resp_cnt_r  <= '0;
            wd_cnt_r    <= '0;
        end else begin
            if ((state_r == RX_IDLE) && !rxDPPLGotSignal_i && !usbResetDetected_i) begin
                if (ipd_cnt_r != IPD_MIN) begin
                    ipd_cnt_r <= ipd_cnt_r + IPD_W'(1);
                end else begin
                    ipd_cnt_r <= ipd_cnt_r;
                end
            end else begin
                ipd_cnt_r <= '0;
            end
            if ((state_r == TX_SETUP) && (state_nxt_s == TX_SETUP)) begin
                setup_cnt_r <= setup_cnt_r + SET_W'(1);
            end else begin
                setup_cnt_r <= '0;
            end
            if ((state_r == RESP_WAIT) && (state_nxt_s == RESP_WAIT)) begin
                resp_cnt_r <= resp_cnt_r + RESP_W'(1);
            end else begin
                resp_cnt_r <= '0;
            end
            if ((state_r == TX_ACTIVE) && (state_nxt_s == TX_ACTIVE)) begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end else begin
                wd_cnt_r <= '0;
            end
        end
    end

    // Latch the response expectation at grant and remember an abort for TX_SETTLE.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            expect_r <= 1'b0;
            abort_r  <= 1'b0;
        end else begin
            if (usbResetDetected_i) begin
                expect_r <= 1'b0;
            end else if (grant_s) begin
                expect_r <= txExpectResponse_i;
            end else begin
                expect_r <= expect_r;
            end
            abort_r <= abort_s;
        end
    end

    assign txGrant_o         = grant_s;
    assign rxTimeout_o       = timeout_s;
    assign txAbort_o         = abort_s;
    assign isSendingPhase_o  = is_sending_r;
    assign busy_o            = busy_r;
    assign txReqSendPacket_o = tx_pkt_r;

`ifdef USB_TURNAROUND_STATS_EN
    logic              usb_reset_q_r;
    logic [STAT_W-1:0] timeout_cnt_r;
    logic [STAT_W-1:0] abort_cnt_r;

    // Saturating event statistics, cleared on a fresh bus reset.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            usb_reset_q_r <= 1'b0;
            timeout_cnt_r <= '0;
            abort_cnt_r   <= '0;
        end else begin
            usb_reset_q_r <= usbResetDetected_i;
            if (usbResetDetected_i && !usb_reset_q_r) begin
                timeout_cnt_r <= '0;
                abort_cnt_r   <= '0;
            end else begin
                if (timeout_s && (timeout_cnt_r != {STAT_W{1'b1}})) begin
                    timeout_cnt_r <= timeout_cnt_r + STAT_W'(1);
                end else begin
                    timeout_cnt_r <= timeout_cnt_r;
                end
                if (abort_s && (abort_cnt_r != {STAT_W{1'b1}})) begin
                    abort_cnt_r <= abort_cnt_r + STAT_W'(1);
                end else begin
                    abort_cnt_r <= abort_cnt_r;
                end
            end
        end
    end

    assign timeoutCount_o = timeout_cnt_r;
    assign abortCount_o   = abort_cnt_r;
`endif

endmodule

// File: tb/tb_usb_sie_turnaround_ctrl.sv
// Testbench for usb_sie_turnaround_ctrl: expected output pulses are queued
// with their cycle stamps as stimulus is driven and matched as they appear.
module tb_usb_sie_turnaround_ctrl;

    localparam int K_GRANT = 0;
    localparam int K_PKT   = 1;
    localparam int K_TMO   = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic usb_reset, rx_dppl, rx_done, tx_req, tx_expect, tx_done;
    logic tx_grant, is_sending, tx_pkt, rx_timeout, tx_abort, busy;
`ifdef USB_TURNAROUND_STATS_EN
    logic [7:0] timeout_count, abort_count;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   c0, d, r, g;

    usb_sie_turnaround_ctrl dut (
        .clk12_i            (clk),
        .rst_i              (rst),
        .usbResetDetected_i (usb_reset),
        .rxDPPLGotSignal_i  (rx_dppl),
        .rxPacketDone_i     (rx_done),
        .txReqSend_i        (tx_req),
        .txExpectResponse_i (tx_expect),
        .txDoneSending_i    (tx_done),
        .txGrant_o          (tx_grant),
        .isSendingPhase_o   (is_sending),
        .txReqSendPacket_o  (tx_pkt),
        .rxTimeout_o        (rx_timeout),
        .txAbort_o          (tx_abort),
        .busy_o             (busy)
`ifdef USB_TURNAROUND_STATS_EN
        ,
        .timeoutCount_o     (timeout_count),
        .abortCount_o       (abort_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 40000) begin
            $display("FAIL run_bound: got cycle %0d, want < 40000", cyc);
            $fatal(1);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", kind, -1);
        end else begin
            e = exp_q.pop_front();
            check_eq("pulse_kind", kind, e.kind);
            check_eq("pulse_cycle", cyc, e.cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_grant)   sb_pop(K_GRANT);
            if (tx_pkt)     sb_pop(K_PKT);
            if (rx_timeout) sb_pop(K_TMO);
            if (tx_abort)   sb_pop(K_ABORT);
        end
    end

    initial begin
        rst = 1'b1; usb_reset = 1'b0; rx_dppl = 1'b0; rx_done = 1'b0;
        tx_req = 1'b1; tx_expect = 1'b1; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_is_sending", int'(is_sending), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_grant", int'(tx_grant), 0);
        check_eq("rst_pkt", int'(tx_pkt), 0);
        check_eq("rst_timeout", int'(rx_timeout), 0);
        check_eq("rst_abort", int'(tx_abort), 0);

        // Grant after reset needs two idle cycles; expect=1 -> response timeout.
        tick(1); rst = 1'b0; c0 = cyc;
        push(K_GRANT, c0 + 2); push(K_PKT, c0 + 4);
        tick(3); tx_req = 1'b0;
        @(negedge clk);
        check_eq("setup_is_sending", int'(is_sending), 1);
        check_eq("setup_busy", int'(busy), 1);
        tick(3); d = cyc; tx_done = 1'b1;
        push(K_TMO, d + 19);
        tick(1); tx_done = 1'b0;
        @(negedge clk);
        check_eq("settle_is_sending", int'(is_sending), 0);
        check_eq("settle_busy", int'(busy), 1);
        tick(1);
        @(negedge clk);
        check_eq("respwait_busy", int'(busy), 1);
        tick(18);
        @(negedge clk);
        check_eq("after_timeout_busy", int'(busy), 0);

        // RX priority, ignored request during RX_BUSY, IPD restart.
        r = cyc; rx_dppl = 1'b1; tx_req = 1'b1; tx_expect = 1'b0;
        tick(1); rx_dppl = 1'b0;
        @(negedge clk);
        check_eq("rxbusy_busy", int'(busy), 1);
        tick(2); rx_done = 1'b1;
        tick(1); rx_done = 1'b0;
        @(negedge clk);
        check_eq("rx_idle_busy", int'(busy), 0);
        tick(1); rx_dppl = 1'b1;
        tick(1); rx_dppl = 1'b0;
        @(negedge clk);
        check_eq("rx_again_busy", int'(busy), 1);
        tick(2); rx_done = 1'b1;
        push(K_GRANT, r + 11); push(K_PKT, r + 13);
        tick(1); rx_done = 1'b0;
        tick(3); tx_req = 1'b0;
        tick(3); tx_done = 1'b1;
        tick(1); tx_done = 1'b0;
        @(negedge clk);
        check_eq("noexp_settle_is_sending", int'(is_sending), 0);
        tick(1);
        @(negedge clk);
        check_eq("noexp_idle_busy", int'(busy), 0);

        // Response arriving on the last wait cycle wins over the timeout.
        tick(2); g = cyc; tx_expect = 1'b1; tx_req = 1'b1;
        push(K_GRANT, g); push(K_PKT, g + 2);
        tick(1); tx_req = 1'b0;
        tick(3); tx_done = 1'b1;
        tick(1); tx_done = 1'b0;
        tick(18); rx_dppl = 1'b1;
        tick(1); rx_dppl = 1'b0;
        @(negedge clk);
        check_eq("late_rx_busy", int'(busy), 1);
        check_eq("late_rx_is_sending", int'(is_sending), 0);
        tick(1); rx_done = 1'b1;
        tick(1); rx_done = 1'b0;

        // Watchdog abort; expect=1 yet no RESP_WAIT afterwards.
        tick(2); g = cyc; tx_req = 1'b1;
        push(K_GRANT, g); push(K_PKT, g + 2); push(K_ABORT, g + 12001);
        tick(1); tx_req = 1'b0;
        tick(12002);
        @(negedge clk);
        check_eq("abort_idle_busy", int'(busy), 0);

        // Done on the watchdog's final cycle: no abort, normal response wait.
        tick(2); g = cyc; tx_req = 1'b1;
        push(K_GRANT, g); push(K_PKT, g + 2);
        tick(1); tx_req = 1'b0;
        tick(12000); tx_done = 1'b1;
        push(K_TMO, g + 12020);
        tick(1); tx_done = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("edge_done_respwait_busy", int'(busy), 1);
        tick(18);
        @(negedge clk);
        check_eq("edge_done_idle_busy", int'(busy), 0);

        // Bus reset during TX_ACTIVE; request held high throughout the reset.
        tick(2); g = cyc; tx_req = 1'b1;
        push(K_GRANT, g); push(K_PKT, g + 2);
        tick(5); usb_reset = 1'b1;
        tick(1);
        @(negedge clk);
        check_eq("usbrst_is_sending", int'(is_sending), 0);
        check_eq("usbrst_busy", int'(busy), 0);
`ifdef USB_TURNAROUND_STATS_EN
        check_eq("usbrst_timeout_count", int'(timeout_count), 0);
        check_eq("usbrst_abort_count", int'(abort_count), 0);
`endif
        tick(15); usb_reset = 1'b0; tx_expect = 1'b0;
        push(K_GRANT, g + 23); push(K_PKT, g + 25);
        tick(3); tx_req = 1'b0;
        tick(3); tx_done = 1'b1;
        tick(1); tx_done = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("post_usbrst_idle_busy", int'(busy), 0);

        tick(5);
        check_eq("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
